// File: rtl/sdc_spi_pkg.sv
// Shared types and helpers for the sdc_spi_gen SPI master.
// Bytes go out least-significant first, each MSB first; byte-swapping lets one MSB-first shifter do both.
package sdc_spi_pkg;

    typedef enum logic [1:0] {
        LEN_8   = 2'b00,
        LEN_16  = 2'b01,
        LEN_32  = 2'b10,
        LEN_RSV = 2'b11
    } len_e;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_e;

    localparam int unsigned BITS_8  = 8;
    localparam int unsigned BITS_16 = 16;
    localparam int unsigned BITS_32 = 32;

    function automatic logic [5:0] len_bits(input len_e l);
        case (l)
            LEN_16:  return 6'(BITS_16);
            LEN_32:  return 6'(BITS_32);
            default: return 6'(BITS_8);
        endcase
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Received bits arrive in serial order at the LSB; left-align, then undo the byte order.
    function automatic logic [31:0] rx_order(input logic [31:0] sr, input len_e l);
        logic [31:0] al;
        case (l)
            LEN_16:  al = {sr[15:0], 16'h0};
            LEN_32:  al = sr;
            default: al = {sr[7:0], 24'h0};
        endcase
        return bswap(al);
    endfunction

endpackage

// File: rtl/sdc_spi_gen_if.sv
// CPU-side request/response bundle for sdc_spi_gen.
interface sdc_spi_gen_if #(
    parameter int unsigned DIVW = 8
);
    logic            start;
    logic [1:0]      len;
    logic [DIVW-1:0] div;
    logic [2:0]      cs_sel;
    logic            cs_hold;
    logic [31:0]     dataTx;
    logic [31:0]     dataRx;
    logic            rdy;

    modport master (
        output start, len, div, cs_sel, cs_hold, dataTx,
        input  dataRx, rdy
    );

    modport slave (
        input  start, len, div, cs_sel, cs_hold, dataTx,
        output dataRx, rdy
    );
endinterface

// File: rtl/sdc_spi_clkgen.sv
// SCLK half-period counter: counts 0..div while enabled and pulses half_end on the last count.
module sdc_spi_clkgen #(
    parameter int unsigned DIVW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            en,
    input  logic [DIVW-1:0] div,
    output logic            half_end
);
    logic [DIVW-1:0] cnt;

    assign half_end = en && (cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || half_end) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + DIVW'(1);
        end
    end
endmodule

// File: rtl/sdc_spi_gen.sv
// MODE 0 SPI master with 8/16/32-bit words, runtime SCLK divider and NCS chip selects.
module sdc_spi_gen
    import sdc_spi_pkg::*;
#(
    parameter int unsigned NCS  = 2,
    parameter int unsigned DIVW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    sdc_spi_gen_if.slave   bus,
    output logic           sclk,
    output logic           mosi,
    input  logic           miso,
    output logic [NCS-1:0] cs_n
);
    state_e          state, state_n;
    len_e            len_q;
    logic [DIVW-1:0] div_q;
    logic            hold_q;
    logic [31:0]     tx_sr;
    logic [31:0]     rx_sr;
    logic [31:0]     rx_q;
    logic [5:0]      bit_cnt;
    logic            accept;
    logic            half_end;
    logic            last_bit;

    assign accept   = (state == IDLE) && bus.start;
    assign last_bit = (bit_cnt == (len_bits(len_q) - 6'd1));

    sdc_spi_clkgen #(.DIVW(DIVW)) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .en       (state != IDLE),
        .div      (div_q),
        .half_end (half_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = LOW;
            LOW:     if (half_end)  state_n = HIGH;
            HIGH:    if (half_end)  state_n = last_bit ? IDLE : LOW;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= LEN_8;
            div_q   <= '0;
            hold_q  <= 1'b0;
            tx_sr   <= '1;
            rx_sr   <= '0;
            rx_q    <= '0;
            bit_cnt <= '0;
            cs_n    <= '1;
        end else if (accept) begin
            len_q   <= len_e'(bus.len);
            div_q   <= bus.div;
            hold_q  <= bus.cs_hold;
            tx_sr   <= bswap(bus.dataTx);
            rx_sr   <= '0;
            bit_cnt <= '0;
            // A new select always replaces any select held from the previous transfer.
            cs_n    <= (32'(bus.cs_sel) < NCS) ? ~(NCS'(1) << bus.cs_sel) : '1;
        end else if (half_end && (state == LOW)) begin
            rx_sr <= {rx_sr[30:0], miso};
        end else if (half_end && (state == HIGH)) begin
            if (last_bit) begin
                rx_q  <= rx_order(rx_sr, len_q);
                tx_sr <= '1;
                if (!hold_q) cs_n <= '1;
            end else begin
                tx_sr   <= {tx_sr[30:0], 1'b1};
                bit_cnt <= bit_cnt + 6'd1;
            end
        end
    end

    assign sclk       = (state == HIGH);
    assign mosi       = (state == IDLE) ? 1'b1 : tx_sr[31];
    assign bus.rdy    = (state == IDLE);
    assign bus.dataRx = rx_q;
endmodule

// File: tb/tb_sdc_spi_gen.sv
// Self-checking bench for sdc_spi_gen: directed table, random transfers against a bit-order model, reset abort.
module tb_sdc_spi_gen;
    localparam int unsigned NCS   = 2;
    localparam int unsigned DIVW  = 8;
    localparam int          LIMIT = 20000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sclk;
    logic           mosi;
    logic           miso;
    logic [NCS-1:0] cs_n;

    sdc_spi_gen_if #(.DIVW(DIVW)) bus ();

    sdc_spi_gen #(.NCS(NCS), .DIVW(DIVW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .sclk  (sclk),
        .mosi  (mosi),
        .miso  (miso),
        .cs_n  (cs_n)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          miso_mode = 0;      // 0 loopback, 1 tied high, 2 slave word
    logic [31:0] slave_word = '0;
    int          idx = 0;
    logic [31:0] last_rx = '0;
    logic        cs0_low = 1'b0;

    // Serial bit k lives at this position in the 32-bit word.
    function automatic int bitpos(input int k);
        if (k < 0 || k > 31) return 0;
        return (k / 8) * 8 + 7 - (k % 8);
    endfunction

    assign miso = (miso_mode == 0) ? mosi :
                  (miso_mode == 1) ? 1'b1 : slave_word[bitpos(idx)];

    function automatic int nbits(input logic [1:0] l);
        if (l == 2'b01) return 16;
        if (l == 2'b10) return 32;
        return 8;
    endfunction

    function automatic logic [31:0] mask(input int n);
        if (n >= 32) return '1;
        return (32'h1 << n) - 32'h1;
    endfunction

    function automatic logic [31:0] exp_mosi(input logic [31:0] tx, input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++) r[k] = tx[bitpos(k)];
        return r;
    endfunction

    function automatic logic [NCS-1:0] cs_mask(input logic [2:0] sel);
        if (32'(sel) < NCS) return ~(NCS'(1) << sel);
        return '1;
    endfunction

    function automatic logic [31:0] model_rx(input int mode, input logic [31:0] tx,
                                             input logic [31:0] sw, input int n);
        if (mode == 0) return tx & mask(n);
        if (mode == 1) return mask(n);
        return sw & mask(n);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Launch at the current (negedge) instant, monitor every cycle until rdy returns, then check.
    task automatic xfer(input string nm, input logic [1:0] l, input logic [7:0] d,
                        input logic [2:0] sel, input logic h, input logic [31:0] tx,
                        input int mode, input logic [31:0] sw, input int glitch_at,
                        input int exp_busy, input logic [31:0] exp_rx,
                        input logic [NCS-1:0] exp_cs_after);
        int n, busy, nrise, hi, hi_max;
        logic [31:0] mbits;
        logic [NCS-1:0] cs_during;
        logic prev_s, moved, done;
        n = nbits(l);
        busy = 0; nrise = 0; hi = 0; hi_max = 0;
        mbits = '0; cs_during = '1; prev_s = 1'b0; moved = 1'b0; done = 1'b0;
        miso_mode = mode; slave_word = sw; idx = 0;
        bus.len = l; bus.div = d; bus.cs_sel = sel; bus.cs_hold = h; bus.dataTx = tx;
        bus.start = 1'b1;
        for (int c = 0; c < LIMIT && !done; c++) begin
            @(negedge clk);
            if (bus.rdy) begin
                done = 1'b1;
            end else begin
                busy++;
                bus.start = (glitch_at > 0 && busy == glitch_at);
                if (bus.start) begin
                    bus.dataTx = ~tx; bus.len = 2'b10; bus.div = 8'd0; bus.cs_sel = 3'd0;
                end
                if (busy == 1) cs_during = cs_n;
                if (sclk && !prev_s) begin
                    if (nrise < 32) mbits[nrise] = mosi;
                    nrise++;
                end
                if (!sclk && prev_s) idx++;
                hi = sclk ? hi + 1 : 0;
                if (hi > hi_max) hi_max = hi;
                if (bus.dataRx !== last_rx) moved = 1'b1;
                if (!cs_n[0]) cs0_low = 1'b1;
                prev_s = sclk;
            end
        end
        bus.start = 1'b0;
        check({nm, " completed"}, 32'(done), 32'd1);
        check({nm, " busy cycles"}, 32'(busy), 32'(exp_busy));
        check({nm, " dataRx"}, bus.dataRx, exp_rx);
        check({nm, " cs_n after"}, 32'(cs_n), 32'(exp_cs_after));
        check({nm, " mosi bits"}, mbits, exp_mosi(tx, n));
        check({nm, " sclk rises"}, 32'(nrise), 32'(n));
        check({nm, " sclk high half"}, 32'(hi_max), 32'(int'(d) + 1));
        check({nm, " cs_n during"}, 32'(cs_during), 32'(cs_mask(sel)));
        check({nm, " dataRx stable while busy"}, 32'(moved), 32'd0);
        last_rx = exp_rx;
    endtask

    typedef struct {
        logic [1:0]     len;
        logic [7:0]     div;
        logic [2:0]     cs_sel;
        logic           hold;
        logic [31:0]    tx;
        int             mode;
        logic [31:0]    sw;
        int             exp_busy;
        logic [31:0]    exp_rx;
        logic [NCS-1:0] exp_cs;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rl;
        logic [7:0]  rd;
        logic [2:0]  rs;
        logic        rh;
        logic [31:0] rt, rw;
        int          rm, rn, cnt;
        logic        found;

        tbl[0] = '{2'b00, 8'd0,   3'd0, 1'b0, 32'h0000_00A5, 0, 32'h0,          16,   32'h0000_00A5, 2'b11};
        tbl[1] = '{2'b10, 8'd3,   3'd0, 1'b0, 32'h1234_5678, 0, 32'h0,          256,  32'h1234_5678, 2'b11};
        tbl[2] = '{2'b01, 8'd255, 3'd0, 1'b0, 32'h0000_0000, 1, 32'h0,          8192, 32'h0000_FFFF, 2'b11};
        tbl[3] = '{2'b01, 8'd1,   3'd1, 1'b1, 32'h0000_BEEF, 2, 32'hCAFE_1234,  64,   32'h0000_1234, 2'b01};
        tbl[4] = '{2'b01, 8'd0,   3'd1, 1'b0, 32'h0000_0000, 2, 32'h0000_8001,  32,   32'h0000_8001, 2'b11};
        tbl[5] = '{2'b11, 8'd2,   3'd7, 1'b1, 32'hFFFF_FF3C, 0, 32'h0,          48,   32'h0000_003C, 2'b11};

        bus.start = 1'b0; bus.len = '0; bus.div = '0; bus.cs_sel = '0;
        bus.cs_hold = 1'b0; bus.dataTx = '0;

        repeat (2) @(negedge clk);
        check("reset rdy", 32'(bus.rdy), 32'd1);
        check("reset sclk", 32'(sclk), 32'd0);
        check("reset mosi", 32'(mosi), 32'd1);
        check("reset cs_n", 32'(cs_n), 32'(2'b11));
        check("reset dataRx", bus.dataRx, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Consecutive calls start in the same cycle rdy rises.
        for (int i = 0; i < 6; i++) begin
            if (i == 3) cs0_low = 1'b0;
            xfer($sformatf("vec%0d", i), tbl[i].len, tbl[i].div, tbl[i].cs_sel, tbl[i].hold,
                 tbl[i].tx, tbl[i].mode, tbl[i].sw, 0, tbl[i].exp_busy, tbl[i].exp_rx,
                 tbl[i].exp_cs);
            if (i == 4) check("hold sequence cs_n[0] untouched", 32'(cs0_low), 32'd0);
        end

        xfer("ignored start", 2'b00, 8'd2, 3'd0, 1'b0, 32'h0000_005A, 0, 32'h0, 10,
             48, 32'h0000_005A, 2'b11);

        for (int i = 0; i < 24; i++) begin
            rl = 2'($urandom_range(0, 3));
            rd = 8'($urandom_range(0, 5));
            rs = 3'($urandom_range(0, 7));
            rh = 1'($urandom_range(0, 1));
            rt = $urandom;
            rw = $urandom;
            rm = $urandom_range(0, 2);
            rn = nbits(rl);
            xfer($sformatf("rand%0d", i), rl, rd, rs, rh, rt, rm, rw, 0,
                 rn * 2 * (int'(rd) + 1), model_rx(rm, rt, rw, rn),
                 rh ? cs_mask(rs) : '1);
        end

        // Abort a 32-bit transfer halfway, while sclk is high.
        miso_mode = 0;
        bus.len = 2'b10; bus.div = 8'd1; bus.cs_sel = 3'd0; bus.cs_hold = 1'b1;
        bus.dataTx = $urandom; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0; found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            if (!bus.rdy) cnt++;
            if (cnt >= 64 && sclk) found = 1'b1;
            else @(negedge clk);
        end
        check("abort mid-transfer reached", 32'(found), 32'd1);
        check("abort cs_n before reset", 32'(cs_n), 32'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        check("abort rdy", 32'(bus.rdy), 32'd1);
        check("abort sclk", 32'(sclk), 32'd0);
        check("abort mosi", 32'(mosi), 32'd1);
        check("abort cs_n", 32'(cs_n), 32'(2'b11));
        check("abort dataRx", bus.dataRx, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rx = '0;
        xfer("post-reset", 2'b00, 8'd1, 3'd1, 1'b0, 32'h0000_00C3, 2, 32'h0000_0096, 0,
             32, 32'h0000_0096, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
